// File: rtl/fib_tx_rdctrl.sv
// Transmit read controller: pops a byte count, then that frame's data words, from show-ahead
// FIFOs and presents them to the MAC as sop/eop-qualified words with byte enables.
//   state | meaning
//   IDLE  | wait for tx_en and a queued byte count
//   LEN   | pop byte count, classify frame (zero / oversize / normal)
//   DATA  | stream words to the MAC under valid/ready
//   DRAIN | discard an oversize frame's words without presenting them
//   IFG   | inter-frame gap countdown
module fib_tx_rdctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int BCNT_WIDTH = 32,
    parameter int MAX_BCNT   = 9600
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic                    tx_en,
    input  logic [7:0]              ifg_cycles,
    input  logic [BCNT_WIDTH-1:0]   rd_txwbcnt_fifo,
    input  logic                    txwbcnt_rdempty,
    output logic                    txwbcnt_rdreq,
    input  logic [DATA_WIDTH-1:0]   rd_txdata_fifo,
    input  logic                    txdata_rdempty,
    output logic                    txdata_rdreq,
    output logic [DATA_WIDTH-1:0]   mac_tx_data,
    output logic [DATA_WIDTH/8-1:0] mac_tx_be,
    output logic                    mac_tx_valid,
    output logic                    mac_tx_sop,
    output logic                    mac_tx_eop,
    input  logic                    mac_tx_ready,
    output logic [31:0]             frame_cnt,
    output logic                    err_zero_len,
    output logic                    err_oversize
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [BCNT_WIDTH:0] ROUND_UP = 7;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        LEN   = 5'b00010,
        DATA  = 5'b00100,
        DRAIN = 5'b01000,
        IFG   = 5'b10000
    } state_t;

    state_t                 state;
    logic [BCNT_WIDTH-1:0]  words_left;
    logic [BE_WIDTH-1:0]    last_be;
    logic                   first_word;
    logic [7:0]             ifg_cnt;

    logic [BCNT_WIDTH:0]    bcnt_round;
    logic [BCNT_WIDTH-1:0]  words;
    logic [2:0]             lanes;
    logic [BE_WIDTH-1:0]    last_be_next;
    logic                   has_words;
    logic                   load;
    logic                   accept;

    always_comb begin
        bcnt_round   = {1'b0, rd_txwbcnt_fifo} + ROUND_UP;
        words        = BCNT_WIDTH'(bcnt_round >> 3);
        lanes        = rd_txwbcnt_fifo[2:0];
        last_be_next = (lanes == 3'd0) ? '1 : ((BE_WIDTH'(1) << lanes) - BE_WIDTH'(1));
        has_words    = (words_left != '0);
        accept       = mac_tx_valid && mac_tx_ready;
        load         = (state == DATA) && has_words && !txdata_rdempty
                       && (!mac_tx_valid || mac_tx_ready);
        txwbcnt_rdreq = (state == LEN) && !txwbcnt_rdempty;
        txdata_rdreq  = load || ((state == DRAIN) && has_words && !txdata_rdempty);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state        <= IDLE;
            words_left   <= '0;
            last_be      <= '0;
            first_word   <= 1'b0;
            ifg_cnt      <= '0;
            mac_tx_data  <= '0;
            mac_tx_be    <= '0;
            mac_tx_valid <= 1'b0;
            mac_tx_sop   <= 1'b0;
            mac_tx_eop   <= 1'b0;
            frame_cnt    <= '0;
            err_zero_len <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            err_zero_len <= 1'b0;
            err_oversize <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_en && !txwbcnt_rdempty)
                        state <= LEN;
                end
                LEN: begin
                    if (!txwbcnt_rdempty) begin
                        first_word <= 1'b1;
                        last_be    <= last_be_next;
                        if (rd_txwbcnt_fifo == '0) begin
                            err_zero_len <= 1'b1;
                            state        <= IDLE;
                        end else if (rd_txwbcnt_fifo > BCNT_WIDTH'(MAX_BCNT)) begin
                            err_oversize <= 1'b1;
                            words_left   <= words;
                            state        <= DRAIN;
                        end else begin
                            words_left <= words;
                            state      <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (load) begin
                        mac_tx_data  <= rd_txdata_fifo;
                        mac_tx_valid <= 1'b1;
                        mac_tx_sop   <= first_word;
                        mac_tx_eop   <= (words_left == BCNT_WIDTH'(1));
                        mac_tx_be    <= (words_left == BCNT_WIDTH'(1)) ? last_be : '1;
                        words_left   <= words_left - BCNT_WIDTH'(1);
                        first_word   <= 1'b0;
                    end else if (accept) begin
                        mac_tx_valid <= 1'b0;
                        mac_tx_sop   <= 1'b0;
                        mac_tx_eop   <= 1'b0;
                    end
                    // words_left is already 0 here, so no load competes with the exit
                    if (accept && mac_tx_eop) begin
                        frame_cnt <= frame_cnt + 32'd1;
                        if (ifg_cycles == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            ifg_cnt <= ifg_cycles;
                            state   <= IFG;
                        end
                    end
                end
                DRAIN: begin
                    if (!has_words)
                        state <= IDLE;
                    else if (txdata_rdreq)
                        words_left <= words_left - BCNT_WIDTH'(1);
                end
                IFG: begin
                    if (ifg_cnt <= 8'd1)
                        state <= IDLE;
                    else
                        ifg_cnt <= ifg_cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
